// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_pkg;

    localparam int DEFAULT_DATA_BITS     = 8;
    localparam int DEFAULT_NUM_REQ       = 4;
    localparam int DEFAULT_START_TIMEOUT = 16;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_START  = 2'd1,
        ARB_ACTIVE = 2'd2
    } arb_state_t;

    // Width of an index or counter able to hold 0..n-1 (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping from NUM_REQ-1 back to 0. The winner is returned one-hot.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int PTR_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner
);

    logic [PTR_W-1:0] idx;
    logic             found;

    // Walk the requesters starting at ptr and keep the first one that is set.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ requesters.
// A request must be seen on two consecutive edges (together with CTS high and
// Tx_Busy low) before it is selected, so a request sampled at edge n produces
// Grant/Transmit_Start after edge n+1 and a one-cycle glitch is never granted.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int DATA_BITS     = DEFAULT_DATA_BITS,
    parameter int NUM_REQ       = DEFAULT_NUM_REQ,
    parameter int START_TIMEOUT = DEFAULT_START_TIMEOUT
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic [NUM_REQ-1:0]           Req,
    input  logic [NUM_REQ*DATA_BITS-1:0] Req_Data,
    input  logic                         CTS,
    input  logic                         Tx_Busy,
    output logic [DATA_BITS-1:0]         Tx_Data,
    output logic                         Transmit_Start,
    output logic [NUM_REQ-1:0]           Grant,
    output logic [NUM_REQ-1:0]           Done,
    output logic                         Timeout_Err
);

    localparam int               PTR_W    = idx_width(NUM_REQ);
    localparam int               CNT_W    = idx_width(START_TIMEOUT);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

    arb_state_t state, state_next;

    logic [PTR_W-1:0]     ptr, ptr_next;
    logic [CNT_W-1:0]     cnt, cnt_next;

    // Previous-edge samples used to qualify a new selection.
    logic [NUM_REQ-1:0]   req_q;
    logic                 cts_q;
    logic                 busy_q;

    logic [NUM_REQ-1:0]   req_eff;
    logic [NUM_REQ-1:0]   winner;
    logic [PTR_W-1:0]     win_idx;
    logic [DATA_BITS-1:0] win_data;
    logic                 launch;

    // Next values of the registered outputs.
    logic [DATA_BITS-1:0] tx_data_next;
    logic                 start_next;
    logic [NUM_REQ-1:0]   grant_next;
    logic [NUM_REQ-1:0]   done_next;
    logic                 timeout_next;

    assign req_eff = Req & req_q;
    assign launch  = (|req_eff) && CTS && cts_q && !Tx_Busy && !busy_q;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req    (req_eff),
        .ptr    (ptr),
        .winner (winner)
    );

    // Turn the one-hot winner into an index and select its byte.
    always_comb begin
        win_idx  = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) begin
                win_idx  = PTR_W'(i);
                win_data = Req_Data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // Keep last-edge copies of the inputs that gate a new selection.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (Rst) begin
            req_q  <= '0;
            cts_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            req_q  <= Req;
            cts_q  <= CTS;
            busy_q <= Tx_Busy;
        end
    end

    // Next-state and next-output logic; outputs hold unless a transition changes them.
    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        cnt_next     = cnt;
        tx_data_next = Tx_Data;
        start_next   = Transmit_Start;
        grant_next   = Grant;
        done_next    = '0;
        timeout_next = 1'b0;

        case (state)
            ARB_IDLE: begin
                if (launch) begin
                    state_next   = ARB_START;
                    grant_next   = winner;
                    tx_data_next = win_data;
                    start_next   = 1'b1;
                    cnt_next     = '0;
                    ptr_next     = (win_idx == LAST_IDX) ? '0 : win_idx + PTR_W'(1);
                end
            end

            ARB_START: begin
                if (Tx_Busy) begin
                    state_next = ARB_ACTIVE;
                    start_next = 1'b0;
                end else if (cnt == CNT_LAST) begin
                    // UART never acknowledged: release the owner without Done.
                    state_next   = ARB_IDLE;
                    start_next   = 1'b0;
                    grant_next   = '0;
                    timeout_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            ARB_ACTIVE: begin
                if (!Tx_Busy) begin
                    state_next = ARB_IDLE;
                    grant_next = '0;
                    done_next  = Grant;
                end
            end

            default: begin
                state_next = ARB_IDLE;
                start_next = 1'b0;
                grant_next = '0;
            end
        endcase
    end

    // State, pointer, counter and all outputs are registered here.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state          <= ARB_IDLE;
            ptr            <= '0;
            cnt            <= '0;
            Tx_Data        <= '0;
            Transmit_Start <= 1'b0;
            Grant          <= '0;
            Done           <= '0;
            Timeout_Err    <= 1'b0;
        end else begin
            state          <= state_next;
            ptr            <= ptr_next;
            cnt            <= cnt_next;
            Tx_Data        <= tx_data_next;
            Transmit_Start <= start_next;
            Grant          <= grant_next;
            Done           <= done_next;
            Timeout_Err    <= timeout_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. Expected transactions are pushed to
// a queue as stimulus is applied; a monitor pops and checks them as the DUT
// grants, completes or times out.
module tb_uart_tx_arbiter;

    localparam int DATA_BITS     = 8;
    localparam int NUM_REQ       = 4;
    localparam int START_TIMEOUT = 16;

    logic                         Clk = 1'b0;
    logic                         Rst;
    logic [NUM_REQ-1:0]           Req;
    logic [NUM_REQ*DATA_BITS-1:0] Req_Data;
    logic                         CTS;
    logic                         Tx_Busy;
    logic [DATA_BITS-1:0]         Tx_Data;
    logic                         Transmit_Start;
    logic [NUM_REQ-1:0]           Grant;
    logic [NUM_REQ-1:0]           Done;
    logic                         Timeout_Err;

    typedef struct {
        int             owner;
        logic [7:0]     data;
        bit             timeout;
    } txn_t;

    txn_t       exp_q[$];
    txn_t       cur;
    bit         in_txn       = 1'b0;
    int         start_cycles = 0;
    logic [3:0] prev_grant   = 4'b0;
    logic [3:0] exp_grant;

    int         checks   = 0;
    int         errors   = 0;
    int         n_grants = 0;
    int         n_ends   = 0;
    int         tb_ptr   = 0;
    bit         uart_en  = 1'b0;
    logic [7:0] req_bytes [NUM_REQ];

    always #5 Clk = ~Clk;

    uart_tx_arbiter #(
        .DATA_BITS     (DATA_BITS),
        .NUM_REQ       (NUM_REQ),
        .START_TIMEOUT (START_TIMEOUT)
    ) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Req            (Req),
        .Req_Data       (Req_Data),
        .CTS            (CTS),
        .Tx_Busy        (Tx_Busy),
        .Tx_Data        (Tx_Data),
        .Transmit_Start (Transmit_Start),
        .Grant          (Grant),
        .Done           (Done),
        .Timeout_Err    (Timeout_Err)
    );

    // Reference round-robin: first set bit at or after p, wrapping.
    function automatic int rr_model(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (p + k) % 4;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic push_expect(input logic [3:0] r, input bit to);
        txn_t t;
        t.owner   = rr_model(r, tb_ptr);
        t.data    = req_bytes[t.owner];
        t.timeout = to;
        exp_q.push_back(t);
        tb_ptr = (t.owner + 1) % 4;
    endtask

    task automatic wait_count(input bit on_ends, input int target, input int budget, input string what);
        int c;
        c = 0;
        while (((on_ends ? n_ends : n_grants) < target) && (c < budget)) begin
            @(posedge Clk);
            #1;
            c++;
        end
        checks++;
        if ((on_ends ? n_ends : n_grants) < target) begin
            errors++;
            $display("FAIL %s: count=%0d required=%0d after %0d cycles", what,
                     (on_ends ? n_ends : n_grants), target, c);
        end
    endtask

    // UART model: Tx_Busy rises 3 cycles after a Transmit_Start rise and holds 12 cycles.
    initial begin
        logic prev_ts;
        prev_ts = 1'b0;
        Tx_Busy = 1'b0;
        forever begin
            @(negedge Clk);
            if (uart_en && (Transmit_Start === 1'b1) && !prev_ts) begin
                repeat (3) @(posedge Clk);
                #1 Tx_Busy = 1'b1;
                repeat (12) @(posedge Clk);
                #1 Tx_Busy = 1'b0;
            end
            prev_ts = (Transmit_Start === 1'b1);
        end
    end

    // Monitor: pops the scoreboard on each new grant and checks completions.
    initial begin
        forever begin
            @(negedge Clk);
            if (Rst) begin
                in_txn = 1'b0;
            end else begin
                if (Grant !== 4'b0 && prev_grant === 4'b0) begin
                    n_grants++;
                    checks++;
                    if (in_txn) begin
                        errors++;
                        $display("FAIL grant_overlap: Grant=%b while owner %0d still active", Grant, cur.owner);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_grant: Grant=%b, none expected", Grant);
                    end else begin
                        cur          = exp_q.pop_front();
                        in_txn       = 1'b1;
                        start_cycles = 0;
                        exp_grant    = 4'b0001 << cur.owner;
                        checks++;
                        if (Grant !== exp_grant) begin
                            errors++;
                            $display("FAIL grant_owner: got %b expected %b", Grant, exp_grant);
                        end
                        checks++;
                        if (Tx_Data !== cur.data) begin
                            errors++;
                            $display("FAIL grant_data: got %h expected %h", Tx_Data, cur.data);
                        end
                        checks++;
                        if (Transmit_Start !== 1'b1) begin
                            errors++;
                            $display("FAIL grant_start: Transmit_Start=%b expected 1", Transmit_Start);
                        end
                    end
                end else if (Grant !== 4'b0 && Grant !== prev_grant) begin
                    checks++;
                    errors++;
                    $display("FAIL grant_switch: Grant %b -> %b without an idle cycle", prev_grant, Grant);
                end

                if (in_txn) begin
                    if (Transmit_Start === 1'b1) start_cycles++;
                    checks++;
                    if (Tx_Data !== cur.data) begin
                        errors++;
                        $display("FAIL tx_data_stable: got %h expected %h", Tx_Data, cur.data);
                    end
                end

                if (Done !== 4'b0) begin
                    checks++;
                    if (!in_txn || cur.timeout) begin
                        errors++;
                        $display("FAIL unexpected_done: Done=%b expected 0000", Done);
                    end else begin
                        exp_grant = 4'b0001 << cur.owner;
                        if (Done !== exp_grant || Grant !== 4'b0 || Timeout_Err !== 1'b0) begin
                            errors++;
                            $display("FAIL done_pulse: Done=%b Grant=%b Timeout_Err=%b expected Done=%b Grant=0000 Timeout_Err=0",
                                     Done, Grant, Timeout_Err, exp_grant);
                        end
                        in_txn = 1'b0;
                        n_ends++;
                    end
                end else if (Timeout_Err !== 1'b0) begin
                    checks++;
                    if (!in_txn || !cur.timeout) begin
                        errors++;
                        $display("FAIL unexpected_timeout: Timeout_Err=%b expected 0", Timeout_Err);
                    end else begin
                        if (start_cycles != START_TIMEOUT || Grant !== 4'b0) begin
                            errors++;
                            $display("FAIL timeout_pulse: start_cycles=%0d Grant=%b expected %0d and 0000",
                                     start_cycles, Grant, START_TIMEOUT);
                        end
                        in_txn = 1'b0;
                        n_ends++;
                    end
                end else if (in_txn && Grant === 4'b0) begin
                    checks++;
                    errors++;
                    $display("FAIL grant_lost: Grant dropped for owner %0d without Done or Timeout_Err", cur.owner);
                end
            end
            prev_grant = Grant;
        end
    end

    task automatic test_reset;
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if ({Tx_Data, Transmit_Start, Grant, Done, Timeout_Err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: Tx_Data=%h Start=%b Grant=%b Done=%b Tout=%b expected all 0",
                     Tx_Data, Transmit_Start, Grant, Done, Timeout_Err);
        end
        Rst = 1'b0;
        @(posedge Clk);
        #1;
        checks++;
        if ({Transmit_Start, Grant, Done, Timeout_Err} !== '0) begin
            errors++;
            $display("FAIL post_reset_idle: Start=%b Grant=%b Done=%b Tout=%b expected all 0",
                     Transmit_Start, Grant, Done, Timeout_Err);
        end
    endtask

    task automatic test_contention;
        int g0, e0;
        g0 = n_grants;
        e0 = n_ends;
        uart_en = 1'b1;
        for (int i = 0; i < 5; i++) push_expect(4'b1111, 1'b0);
        Req = 4'b1111;
        wait_count(1'b0, g0 + 5, 300, "contention_grants");
        Req = 4'b0000;
        wait_count(1'b1, e0 + 5, 100, "contention_done");
    endtask

    task automatic test_single;
        int e0;
        e0 = n_ends;
        uart_en = 1'b1;
        push_expect(4'b0001, 1'b0);
        @(posedge Clk);
        #1 Req = 4'b0001;
        @(posedge Clk);
        #1;
        checks++;
        if (Grant !== 4'b0000) begin
            errors++;
            $display("FAIL single_early: Grant=%b expected 0000 one edge after request", Grant);
        end
        @(posedge Clk);
        #1;
        checks++;
        if (Grant !== 4'b0001 || Transmit_Start !== 1'b1 || Tx_Data !== 8'hA5) begin
            errors++;
            $display("FAIL single_latency: Grant=%b Start=%b Tx_Data=%h expected 0001 1 a5",
                     Grant, Transmit_Start, Tx_Data);
        end
        // Requester withdraws and CTS drops mid-transaction; neither may abort it.
        Req = 4'b0000;
        CTS = 1'b0;
        wait_count(1'b1, e0 + 1, 60, "single_done");
        CTS = 1'b1;
        checks++;
        if (Tx_Data !== 8'hA5 || Grant !== 4'b0000) begin
            errors++;
            $display("FAIL single_after: Tx_Data=%h Grant=%b expected a5 0000", Tx_Data, Grant);
        end
    endtask

    task automatic test_req_drop;
        int g0;
        g0 = n_grants;
        @(posedge Clk);
        #1 Req = 4'b0100;
        @(posedge Clk);
        #1 Req = 4'b0000;
        repeat (6) @(posedge Clk);
        #1;
        checks++;
        if (n_grants != g0 || Grant !== 4'b0000) begin
            errors++;
            $display("FAIL req_drop: grants=%0d Grant=%b expected %0d 0000", n_grants, Grant, g0);
        end
    endtask

    task automatic test_flow_control;
        int e0;
        e0 = n_ends;
        @(posedge Clk);
        #1;
        CTS = 1'b0;
        Req = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk);
            #1;
            checks++;
            if (Grant !== 4'b0000 || Transmit_Start !== 1'b0) begin
                errors++;
                $display("FAIL cts_hold: cycle %0d Grant=%b Start=%b expected 0000 0", i, Grant, Transmit_Start);
            end
        end
        push_expect(4'b0010, 1'b0);
        CTS = 1'b1;
        @(posedge Clk);
        #1;
        checks++;
        if (Grant !== 4'b0000) begin
            errors++;
            $display("FAIL cts_early: Grant=%b expected 0000", Grant);
        end
        @(posedge Clk);
        #1;
        checks++;
        if (Grant !== 4'b0010 || Transmit_Start !== 1'b1) begin
            errors++;
            $display("FAIL cts_release: Grant=%b Start=%b expected 0010 1", Grant, Transmit_Start);
        end
        Req = 4'b0000;
        wait_count(1'b1, e0 + 1, 60, "flow_done");
    endtask

    task automatic test_timeout;
        int g0, e0;
        g0 = n_grants;
        e0 = n_ends;
        uart_en = 1'b0;
        push_expect(4'b1111, 1'b1);
        push_expect(4'b1111, 1'b0);
        Req = 4'b1111;
        wait_count(1'b1, e0 + 1, 60, "timeout_end");
        uart_en = 1'b1;
        wait_count(1'b0, g0 + 2, 30, "timeout_next_grant");
        Req = 4'b0000;
        wait_count(1'b1, e0 + 2, 60, "timeout_next_done");
    endtask

    task automatic test_reset_active;
        int g0, e0;
        g0 = n_grants;
        uart_en = 1'b1;
        push_expect(4'b0010, 1'b0);
        Req = 4'b0010;
        wait_count(1'b0, g0 + 1, 30, "rst_txn_grant");
        Req = 4'b0000;
        repeat (6) @(posedge Clk);
        #1;
        checks++;
        if (Grant !== 4'b0010 || Transmit_Start !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_active: Grant=%b Start=%b expected 0010 0", Grant, Transmit_Start);
        end
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        checks++;
        if ({Tx_Data, Transmit_Start, Grant, Done, Timeout_Err} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: Tx_Data=%h Start=%b Grant=%b Done=%b Tout=%b expected all 0",
                     Tx_Data, Transmit_Start, Grant, Done, Timeout_Err);
        end
        Rst = 1'b0;
        tb_ptr = 0;
        e0 = n_ends;
        repeat (12) @(posedge Clk);
        #1;
        checks++;
        if (n_ends != e0 || Grant !== 4'b0000) begin
            errors++;
            $display("FAIL rst_abandon: ends=%0d Grant=%b expected %0d 0000", n_ends, Grant, e0);
        end
        // From ptr=0 requester 1 wins; a pointer left at 2 would pick 3.
        push_expect(4'b1010, 1'b0);
        Req = 4'b1010;
        wait_count(1'b0, g0 + 2, 40, "rst_ptr_grant");
        Req = 4'b0000;
        wait_count(1'b1, e0 + 1, 60, "rst_ptr_done");
        push_expect(4'b1000, 1'b0);
        Req = 4'b1000;
        wait_count(1'b0, g0 + 3, 40, "rst_req3_grant");
        Req = 4'b0000;
        wait_count(1'b1, e0 + 2, 60, "rst_req3_done");
    endtask

    initial begin
        req_bytes[0] = 8'hA5;
        req_bytes[1] = 8'h96;
        req_bytes[2] = 8'h3C;
        req_bytes[3] = 8'hD4;
        Req_Data = {req_bytes[3], req_bytes[2], req_bytes[1], req_bytes[0]};
        Req = 4'b0000;
        CTS = 1'b1;
        Rst = 1'b1;

        test_reset();
        test_contention();
        test_single();
        test_req_drop();
        test_flow_control();
        test_timeout();
        test_reset_active();

        repeat (4) @(posedge Clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected transactions never granted", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DATA_BITS, default 8: width of each transmit byte.
REQ-002 Parameter NUM_REQ, default 4: number of requesters.
REQ-003 Parameter START_TIMEOUT, default 16: Clk cycles allowed in START for Tx_Busy to rise.
REQ-004 Port Clk  in  1: single clock; all logic SHALL be on posedge Clk.
REQ-005 Port Rst  in  1: synchronous, active-high reset.
REQ-006 Port Req  in  NUM_REQ: per-requester transmit request, held until Grant.
REQ-007 Port Req_Data  in  NUM_REQ*DATA_BITS: byte for requester i at bits [i*DATA_BITS +: DATA_BITS].
REQ-008 Port CTS  in  1: flow control; a new transmission SHALL start only while high.
REQ-009 Port Tx_Busy  in  1: transmitter busy status from the UART.
REQ-010 Port Tx_Data  out  DATA_BITS: byte to the UART transmitter.
REQ-011 Port Transmit_Start  out  1: start strobe to the UART.
REQ-012 Port Grant  out  NUM_REQ: one-hot owner indicator, high from START through ACTIVE.
REQ-013 Port Done  out  NUM_REQ: one-cycle pulse to the owner on completion.
REQ-014 Port Timeout_Err  out  1: one-cycle pulse on start timeout.
REQ-015 All outputs SHALL be registered.

Function
REQ-016 The FSM SHALL have states IDLE, START and ACTIVE.
REQ-017 IDLE->START when any Req, CTS=1 and Tx_Busy=0: winner picked, Req_Data[winner] latched, Grant[winner] set.
REQ-018 Arbitration SHALL be round-robin: search begins at ptr, wraps NUM_REQ-1->0, and ptr <= winner+1 mod NUM_REQ on selection.
REQ-019 Latency: Req sampled high in IDLE at edge n SHALL give Grant and Transmit_Start high after edge n+1.
REQ-020 In START, Transmit_Start=1 and Tx_Data=latched byte; Tx_Data SHALL remain stable until the next selection.
REQ-021 START->ACTIVE on the first cycle Tx_Busy=1; Transmit_Start SHALL drop in that transition.
REQ-022 START SHALL count cycles; after START_TIMEOUT cycles without Tx_Busy: Timeout_Err pulse, Grant cleared, no Done, ->IDLE, ptr keeps its advanced value.
REQ-023 ACTIVE->IDLE on Tx_Busy=0: Done[owner] pulses one cycle and Grant clears in the same cycle.
REQ-024 At least one IDLE cycle SHALL occur between transmissions, even when Req is pending at completion.
REQ-025 A Req dropped before selection SHALL NOT be granted; a Req dropped after Grant SHALL NOT affect the transaction.
REQ-026 While CTS=0 or Tx_Busy=1 (e.g. BIST activity) in IDLE, the block SHALL wait without granting.
REQ-027 A CTS drop in START or ACTIVE SHALL NOT abort the transaction.

Reset
REQ-028 On Rst: state=IDLE, ptr=0, timeout count=0.
REQ-029 On Rst, all outputs SHALL be 0: Tx_Data, Transmit_Start, Grant, Done and Timeout_Err.
REQ-030 Rst mid-transaction SHALL abandon it with no Done or Timeout_Err pulse.

Structure
REQ-031 Package uart_pkg SHALL hold the state enum arb_state_t and the default DATA_BITS constant.
REQ-032 The round-robin search SHALL be the combinational sub-module uart_rr_pick, with inputs Req and ptr and a one-hot winner output.

Verification
REQ-033 Single request: Req=0001, Req_Data[0]=8'hA5, CTS=1; Tx_Busy rises 3 cycles after Transmit_Start and holds 12 cycles -> Tx_Data=A5, Grant=0001, one Done[0] pulse, Timeout_Err=0.
REQ-034 Contention: Req=1111 held and ptr=0 -> grant order 0,1,2,3,0, each Done before the next Grant, each gap >=1 IDLE cycle.
REQ-035 Flow control: CTS=0 with Req=0010 for 20 cycles -> Grant=0 and Transmit_Start=0; CTS=1 -> Grant=0010 one cycle later.
REQ-036 Timeout: Tx_Busy held 0 -> Transmit_Start high exactly 16 cycles, then Timeout_Err pulse, no Done, next Grant goes to ptr+1.
REQ-037 Reset in ACTIVE: Rst pulsed mid-transmission -> next cycle all outputs 0, no Done, and a subsequent Req=1000 is granted from ptr=0.
